// File: rtl/decrementer_4bit_seq.sv
// Loadable down-counter with prescaled ripple-borrow decrement and a one-cycle done pulse.
// Optional build macro DECR_AUTORELOAD_EN: restart from the last loaded value on each expiry.
module decrementer_4bit_seq #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] dec;
  logic             step;

`ifdef DECR_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Half-subtractor chain; the borrow out of the top stage is never needed.
  always_comb begin
    borrow    = '0;
    borrow[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      borrow[i] = ~count_q[i-1] & borrow[i-1];
    end
    dec = count_q ^ borrow;
  end

  assign step = enable && (pre_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
`ifdef DECR_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          count_d = load_value;
          pre_d   = '0;
`ifdef DECR_AUTORELOAD_EN
          reload_d = load_value;
`endif
          state_d = (load_value != '0) ? S_COUNT : S_FINISH;
        end
      end
      S_COUNT: begin
        // abort takes priority over a simultaneous terminal decrement
        if (abort) begin
          count_d = '0;
          pre_d   = '0;
          state_d = S_IDLE;
        end else if (step) begin
          pre_d   = '0;
          count_d = dec;
          if (dec == '0) state_d = S_FINISH;
        end else if (enable) begin
          pre_d = pre_q + PW'(1);
        end
      end
      S_FINISH: begin
`ifdef DECR_AUTORELOAD_EN
        if (reload_q != '0) begin
          count_d = reload_q;
          pre_d   = '0;
          state_d = S_COUNT;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pre_q   <= '0;
`ifdef DECR_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
`ifdef DECR_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count      = count_q;
  assign busy       = (state_q == S_COUNT);
  assign done       = (state_q == S_FINISH);
  assign load_ready = (state_q == S_IDLE);

endmodule
